// File: rtl/div_seq_if.sv
// Execute-stage <-> divider bundle: operands and controls in, {HI,LO} result and status out.
interface div_seq_if #(parameter int WIDTH = 32);
  logic               start_i;
  logic               signed_i;
  logic               annul_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stall_o;
  logic               divzero_o;

  modport master (
    output start_i, signed_i, annul_i, opdata1_i, opdata2_i,
    input  result_o, ready_o, stall_o, divzero_o
  );

  modport slave (
    input  start_i, signed_i, annul_i, opdata1_i, opdata2_i,
    output result_o, ready_o, stall_o, divzero_o
  );
endinterface

// File: rtl/div_seq.sv
// Restoring radix-2 DIV/DIVU sequencer: result 33 cycles after accept (2 on a zero divisor with DIV_BYZERO_TRAP_EN).
// No result backpressure: ready_o pulses once for the hilo write; stall_o holds F/D/E while busy.
module div_seq #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst,
  div_seq_if.slave bus
);

`ifdef DIV_BYZERO_TRAP_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE, ZERO} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t             state;
  logic [WIDTH-1:0]   dvd;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   dsr;
  logic [5:0]         cnt;
  logic               neg_q;
  logic               neg_r;
  logic [2*WIDTH-1:0] result;
  logic               ready;
  logic               divzero;

  logic               accept;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;
  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic               sign1;
  logic               sign2;

  assign accept = (state == IDLE) && bus.start_i && !bus.annul_i;
  assign sign1  = bus.signed_i && bus.opdata1_i[WIDTH-1];
  assign sign2  = bus.signed_i && bus.opdata2_i[WIDTH-1];
  // Negating 0x80..0 yields 0x80..0, which is the correct unsigned magnitude.
  assign mag1   = sign1 ? -bus.opdata1_i : bus.opdata1_i;
  assign mag2   = sign2 ? -bus.opdata2_i : bus.opdata2_i;

  // The quotient is shifted into the dividend register as the dividend bits shift out.
  always_comb begin
    shifted = {rem, dvd[WIDTH-1]};
    trial   = shifted - {1'b0, dsr};
    q_bit   = (shifted >= {1'b0, dsr});
    rem_nxt = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nxt = {dvd[WIDTH-2:0], q_bit};
  end

  always_comb begin
    bus.stall_o = accept || (state == RUN);
`ifdef DIV_BYZERO_TRAP_EN
    bus.stall_o = bus.stall_o || (state == ZERO);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dvd     <= '0;
      rem     <= '0;
      dsr     <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      result  <= '0;
      ready   <= 1'b0;
      divzero <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dvd   <= mag1;
            dsr   <= mag2;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= sign1 ^ sign2;
            neg_r <= sign1;
            state <= RUN;
`ifdef DIV_BYZERO_TRAP_EN
            if (bus.opdata2_i == '0) state <= ZERO;
`endif
          end
        end
        RUN: begin
          if (bus.annul_i) begin
            state <= IDLE;
          end else begin
            rem <= rem_nxt;
            dvd <= quo_nxt;
            cnt <= cnt + 6'd1;
            if (cnt == 6'(WIDTH - 1)) begin
              state   <= DONE;
              ready   <= 1'b1;
              divzero <= 1'b0;
              result  <= {(neg_r ? -rem_nxt : rem_nxt), (neg_q ? -quo_nxt : quo_nxt)};
            end
          end
        end
`ifdef DIV_BYZERO_TRAP_EN
        ZERO: begin
          if (bus.annul_i) begin
            state <= IDLE;
          end else begin
            state   <= DONE;
            ready   <= 1'b1;
            divzero <= 1'b1;
            result  <= '0;
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.result_o = result;
  assign bus.ready_o  = ready;
`ifdef DIV_BYZERO_TRAP_EN
  assign bus.divzero_o = divzero;
`else
  assign bus.divzero_o = 1'b0;
`endif

endmodule

// File: tb/tb_div_seq.sv
// Scoreboarded bench for div_seq: randomized and directed divides against an arithmetic reference model.
module tb_div_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_seq_if #(.WIDTH(W)) bus();
  div_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [63:0] res;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t        sbq[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          ready_seen = 0;
  logic [63:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer division; zero divisor follows the documented restoring outcome.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [63:0] res, output logic dz, output int lat);
    longint sa, sb, q, r;
    dz  = 1'b0;
    lat = 33;
    if (b == 32'd0) begin
`ifdef DIV_BYZERO_TRAP_EN
      res = '0;
      dz  = 1'b1;
      lat = 2;
`else
      res = {a, ((s && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF)};
`endif
    end else begin
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
      end else begin
        sa = longint'(a);
        sb = longint'(b);
      end
      q   = sa / sb;
      r   = sa % sb;
      res = {r[31:0], q[31:0]};
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.ready_o === 1'b1) begin
      ready_seen++;
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ready actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = sbq.pop_front();
        chk("result", bus.result_o, e.res);
        chk("divzero", {63'd0, bus.divzero_o}, {63'd0, e.dz});
        chk("ready_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] res;
    logic        dz;
    int          lat;
    int          stall_cnt;
    bit          done;
    exp_t        e;
    model(a, b, s, res, dz, lat);
    @(posedge clk); #1;
    bus.start_i   = 1'b1;
    bus.signed_i  = s;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    e.res = res; e.dz = dz; e.cyc = cyc + lat;
    sbq.push_back(e);
    last_res  = res;
    stall_cnt = 0;
    done      = 1'b0;
    @(negedge clk);
    if (bus.stall_o) stall_cnt++;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (bus.stall_o) stall_cnt++;
      if (bus.ready_o) begin
        done = 1'b1;
        break;
      end
    end
    chk("ready_arrived", {63'd0, done}, 64'd1);
    chk("stall_cycles", 64'(stall_cnt), 64'(lat));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b;
    logic        s;
    int          rs0, rcount;
    logic [63:0] prev;
    exp_t        e;

    rst = 1'b1;
    bus.start_i = 1'b0; bus.signed_i = 1'b0; bus.annul_i = 1'b0;
    bus.opdata1_i = '0; bus.opdata2_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_result", bus.result_o, 64'd0);
    chk("rst_ready", {63'd0, bus.ready_o}, 64'd0);
    chk("rst_stall", {63'd0, bus.stall_o}, 64'd0);
    chk("rst_divzero", {63'd0, bus.divzero_o}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    issue(32'd100, 32'd7, 1'b0);
    chk("divu_100_7", bus.result_o, 64'h00000002_0000000E);
    issue(32'hFFFF_FFF9, 32'd2, 1'b1);
    chk("div_m7_2", bus.result_o, 64'hFFFFFFFF_FFFFFFFD);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    chk("div_ovf", bus.result_o, 64'h00000000_80000000);
    issue(32'd5, 32'd0, 1'b0);
`ifdef DIV_BYZERO_TRAP_EN
    chk("divu_5_0", bus.result_o, 64'd0);
    chk("divu_5_0_dz", {63'd0, bus.divzero_o}, 64'd1);
`else
    chk("divu_5_0", bus.result_o, 64'h00000005_FFFFFFFF);
    chk("divu_5_0_dz", {63'd0, bus.divzero_o}, 64'd0);
`endif

    // Annul at RUN cycle 10: stall high while sampled, low after, no result.
    prev = last_res;
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.signed_i = 1'b0;
    bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3;
    @(posedge clk); #1 bus.start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.annul_i = 1'b1;
    @(negedge clk);
    chk("annul_stall_hold", {63'd0, bus.stall_o}, 64'd1);
    @(posedge clk); #1 bus.annul_i = 1'b0;
    @(negedge clk);
    chk("annul_stall_drop", {63'd0, bus.stall_o}, 64'd0);
    rcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.ready_o) rcount++;
    end
    chk("annul_no_ready", 64'(rcount), 64'd0);
    chk("annul_result_kept", bus.result_o, prev);

    // Reset mid-RUN, then back-to-back DIVU 9/3 with start held through DONE.
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.opdata1_i = 32'd12345; bus.opdata2_i = 32'd17;
    @(posedge clk); #1 bus.start_i = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_result", bus.result_o, 64'd0);
    chk("mid_rst_ready", {63'd0, bus.ready_o}, 64'd0);
    chk("mid_rst_stall", {63'd0, bus.stall_o}, 64'd0);
    chk("mid_rst_divzero", {63'd0, bus.divzero_o}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    rs0 = ready_seen;
    @(posedge clk); #1;
    bus.start_i = 1'b1; bus.signed_i = 1'b0;
    bus.opdata1_i = 32'd9; bus.opdata2_i = 32'd3;
    e.res = 64'h00000000_00000003; e.dz = 1'b0; e.cyc = cyc + 33;
    sbq.push_back(e);
    e.cyc = cyc + 67;
    sbq.push_back(e);
    repeat (40) @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (40) @(negedge clk);
    chk("b2b_pulses", 64'(ready_seen - rs0), 64'd2);
    chk("b2b_result", bus.result_o, 64'h00000000_00000003);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      s = 1'($urandom_range(0, 1));
      issue(a, b, s);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
